// File: rtl/caesar_pkg.sv
// Shared constants, types and character helpers for the Caesar decipher pipeline.
package caesar_pkg;

    localparam logic [5:0] ALPHA_LEN = 6'd26;
    localparam logic [4:0] KEY_MAX   = 5'd26;
    localparam logic [7:0] UPPER_A   = 8'h41;
    localparam logic [7:0] UPPER_Z   = 8'h5A;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_Z   = 8'h7A;
    localparam logic [7:0] NULL_CHAR = 8'h00;

    // Shift amount plus direction (0 = right, 1 = left), as used by the cipher side.
    typedef struct packed {
        logic [4:0] num;
        logic       dir;
    } key_t;

    typedef enum logic [1:0] {
        ST_NOKEY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic is_upper(input logic [7:0] ch);
        return (ch >= UPPER_A) && (ch <= UPPER_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] ch);
        return (ch >= LOWER_A) && (ch <= LOWER_Z);
    endfunction

    function automatic logic is_letter(input logic [7:0] ch);
        return is_upper(ch) || is_lower(ch);
    endfunction

    // Undo one shift; a shift of 26 maps every letter onto itself.
    function automatic logic [7:0] unshift_char(input logic [7:0] ch, input key_t key);
        logic [7:0] base;
        logic [5:0] off;
        logic [5:0] t;
        logic [5:0] wrapped;
        base = is_upper(ch) ? UPPER_A : LOWER_A;
        off  = 6'(ch - base);
        if (key.dir)
            t = off + {1'b0, key.num};
        else
            t = off + ALPHA_LEN - {1'b0, key.num};
        wrapped = (t >= ALPHA_LEN) ? (t - ALPHA_LEN) : t;
        if (is_letter(ch))
            return base + {2'b00, wrapped};
        else
            return ch;
    endfunction

    // Middle key of the three-stage cipher: K2 = (K1 + K3) mod 26, D2 = D1 ^ D3.
    function automatic key_t derive_k2(input key_t k1, input key_t k3);
        logic [5:0] sum;
        sum = {1'b0, k1.num} + {1'b0, k3.num};
        return key_t'{num: 5'((sum >= ALPHA_LEN) ? (sum - ALPHA_LEN) : sum),
                      dir: k1.dir ^ k3.dir};
    endfunction

    function automatic logic keys_valid(input logic [4:0] k1_num, input logic [4:0] k3_num);
        return (k1_num <= KEY_MAX) && (k3_num <= KEY_MAX) && (k1_num != k3_num);
    endfunction

endpackage

// File: rtl/caesar_unshift_stage.sv
// One registered decipher stage: undoes a single shift, carries valid and
// non-letter error sidebands, and holds everything while en is low.
module caesar_unshift_stage
    import caesar_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    input  logic       in_err,
    input  key_t       key,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       out_err
);

    logic       valid_reg;
    logic [7:0] char_reg;
    logic       err_reg;

    // Advance with the rest of the pipeline; data only changes when a real char arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            char_reg  <= NULL_CHAR;
            err_reg   <= 1'b0;
        end else if (en) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                char_reg <= unshift_char(in_char, key);
                err_reg  <= in_err | ~is_letter(in_char);
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_char  = char_reg;
    assign out_err   = err_reg;

endmodule

// File: rtl/caesar_decipher_pipeline.sv
// Three-stage streaming Caesar decipher (undoes K3, then K2, then K1).
// Keys are swapped only once the pipeline has drained.
// Optional statistics counters are built when CAESAR_DECIPHER_STATS_EN is defined.
module caesar_decipher_pipeline
    import caesar_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    output logic             key_ready,
    input  logic [4:0]       k1_num,
    input  logic             k1_dir,
    input  logic [4:0]       k3_num,
    input  logic             k3_dir,
    output logic             key_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_char_err,
    output logic [CNT_W-1:0] stat_chars,
    output logic [CNT_W-1:0] stat_errs
);

    state_t state_reg;
    state_t state_next;

    key_t pending_k1_reg;
    key_t pending_k3_reg;
    key_t active_k1_reg;
    key_t active_k3_reg;
    logic key_err_reg;

    logic adv;
    logic key_accept;
    logic pipe_empty;

    // Stage chain: index 0 is the input side, index 3 the output register.
    logic [3:0]      chain_valid;
    logic [3:0][7:0] chain_char;
    logic [3:0]      chain_err;
    key_t [2:0]      stage_key;

    assign adv        = !out_valid || out_ready;
    assign key_accept = key_load && key_ready;
    assign pipe_empty = (chain_valid[3:1] == 3'b000);

    assign chain_valid[0] = in_valid && in_ready;
    assign chain_char[0]  = in_char;
    assign chain_err[0]   = 1'b0;

    assign stage_key[0] = active_k3_reg;
    assign stage_key[1] = derive_k2(active_k1_reg, active_k3_reg);
    assign stage_key[2] = active_k1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stage
            caesar_unshift_stage u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (adv),
                .in_valid  (chain_valid[gi]),
                .in_char   (chain_char[gi]),
                .in_err    (chain_err[gi]),
                .key       (stage_key[gi]),
                .out_valid (chain_valid[gi+1]),
                .out_char  (chain_char[gi+1]),
                .out_err   (chain_err[gi+1])
            );
        end
    endgenerate

    assign out_valid    = chain_valid[3];
    assign out_char     = chain_char[3];
    assign out_char_err = chain_err[3];
    assign key_err      = key_err_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_NOKEY;
        else
            state_reg <= state_next;
    end

    // FSM next state and handshake readies.
    always_comb begin
        state_next = state_reg;
        key_ready  = (state_reg != ST_DRAIN);
        in_ready   = 1'b0;
        case (state_reg)
            ST_NOKEY: begin
                if (key_accept)
                    state_next = ST_DRAIN;
            end
            ST_RUN: begin
                in_ready = adv;
                if (key_accept)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipe_empty)
                    state_next = keys_valid(pending_k1_reg.num, pending_k3_reg.num) ? ST_RUN : ST_NOKEY;
            end
            default: state_next = ST_NOKEY;
        endcase
    end

    // Key capture on request; activation and validity check once the pipe is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_k1_reg <= '0;
            pending_k3_reg <= '0;
            active_k1_reg  <= '0;
            active_k3_reg  <= '0;
            key_err_reg    <= 1'b0;
        end else begin
            if (key_accept) begin
                pending_k1_reg <= key_t'{num: k1_num, dir: k1_dir};
                pending_k3_reg <= key_t'{num: k3_num, dir: k3_dir};
            end
            if ((state_reg == ST_DRAIN) && pipe_empty) begin
                active_k1_reg <= pending_k1_reg;
                active_k3_reg <= pending_k3_reg;
                key_err_reg   <= !keys_valid(pending_k1_reg.num, pending_k3_reg.num);
            end
        end
    end

`ifdef CAESAR_DECIPHER_STATS_EN
    logic [CNT_W-1:0] stat_chars_reg;
    logic [CNT_W-1:0] stat_errs_reg;

    // Saturating counts of output handshakes; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_chars_reg <= '0;
            stat_errs_reg  <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_chars_reg != '1)
                stat_chars_reg <= stat_chars_reg + 1'b1;
            if (out_char_err && (stat_errs_reg != '1))
                stat_errs_reg <= stat_errs_reg + 1'b1;
        end
    end

    assign stat_chars = stat_chars_reg;
    assign stat_errs  = stat_errs_reg;
`else
    assign stat_chars = '0;
    assign stat_errs  = '0;
`endif

endmodule

// File: tb/tb_caesar_decipher_pipeline.sv
// Self-checking bench for caesar_decipher_pipeline: fixed vectors, corner
// sequences (backpressure, key swap, reset) and a randomized stream against
// a modular-arithmetic reference model.
module tb_caesar_decipher_pipeline;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             key_load;
    logic             key_ready;
    logic [4:0]       k1_num;
    logic             k1_dir;
    logic [4:0]       k3_num;
    logic             k3_dir;
    logic             key_err;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_char;
    logic             out_char_err;
    logic [CNT_W-1:0] stat_chars;
    logic [CNT_W-1:0] stat_errs;

    caesar_decipher_pipeline #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_ready    (key_ready),
        .k1_num       (k1_num),
        .k1_dir       (k1_dir),
        .k3_num       (k3_num),
        .k3_dir       (k3_dir),
        .key_err      (key_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_char      (in_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_char     (out_char),
        .out_char_err (out_char_err),
        .stat_chars   (stat_chars),
        .stat_errs    (stat_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic       err;
    } exp_t;

    typedef struct {
        int         k1n;
        bit         k1d;
        int         k3n;
        bit         k3d;
        logic [7:0] ch;
        logic [7:0] exp_ch;
        bit         exp_err;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   m_k1n = 0;
    int   m_k3n = 0;
    bit   m_k1d = 0;
    bit   m_k3d = 0;
    bit   key_acc;
    int   n_out = 0;
    int   n_err = 0;
    int   n_tx  = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: the cipher shifted right by +k or left by -k with K2 derived
    // from K1/K3; deciphering subtracts the net shift modulo 26.
    function automatic exp_t model(input logic [7:0] ch);
        exp_t r;
        int base, k2, net, v;
        bit d2;
        if (ch >= 8'h41 && ch <= 8'h5A)      base = 65;
        else if (ch >= 8'h61 && ch <= 8'h7A) base = 97;
        else begin
            r.ch = ch; r.err = 1'b1;
            return r;
        end
        k2  = (m_k1n + m_k3n) % 26;
        d2  = m_k1d ^ m_k3d;
        net = (m_k1d ? -m_k1n : m_k1n) + (d2 ? -k2 : k2) + (m_k3d ? -m_k3n : m_k3n);
        v   = ((int'(ch) - base - net) % 26 + 26) % 26;
        r.ch  = 8'(base + v);
        r.err = 1'b0;
        return r;
    endfunction

    // One clock: score handshakes that will happen on the coming edge, then advance.
    task automatic tick();
        exp_t e;
        #1;
        key_acc = 1'b0;
        if (out_valid && out_ready) begin
            n_out++;
            if (out_char_err) n_err++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got=0x%0h expected=none", out_char);
            end else begin
                e = exp_q.pop_front();
                n_tx++;
                $display("tx %0d: out=0x%02h err=%0b model=0x%02h/%0b", n_tx, out_char, out_char_err, e.ch, e.err);
                check("stream_char", out_char, e.ch);
                check("stream_err", out_char_err, e.err);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_char));
        if (key_load && key_ready) begin
            key_acc = 1'b1;
            m_k1n = int'(k1_num); m_k1d = k1_dir;
            m_k3n = int'(k3_num); m_k3d = k3_dir;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_keys(input int a, input bit ad, input int b, input bit bd);
        int n;
        bit ok;
        k1_num = 5'(a); k1_dir = ad;
        k3_num = 5'(b); k3_dir = bd;
        key_load = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!key_acc && n < 40);
        key_load = 1'b0;
        if (!key_acc) begin
            total++; bad++;
            $display("FAIL key_accept_timeout: got=none expected=accept");
        end
        n = 0;
        while (!key_ready && n < 40) begin tick(); n++; end
        ok = (a <= 26) && (b <= 26) && (a != b);
        $display("keys K1=%0d/%0d K3=%0d/%0d key_err=%0b", a, ad, b, bd, key_err);
        check("key_ready_after_load", key_ready, 1);
        check("key_err_after_load", key_err, ok ? 0 : 1);
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)      return 8'(65 + $urandom_range(0, 25));
        else if (r < 8) return 8'(97 + $urandom_range(0, 25));
        else            return 8'($urandom_range(0, 255));
    endfunction

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        vecs[0] = '{3, 0, 5, 0, 8'h55, 8'h45, 0};   // U -> E
        vecs[1] = '{20, 1, 4, 0, 8'h62, 8'h70, 0};  // b -> p (wraps)
        vecs[2] = '{20, 1, 4, 0, 8'h21, 8'h21, 1};  // ! passes with err
        vecs[3] = '{3, 0, 5, 0, 8'h61, 8'h6B, 0};   // a -> k
        vecs[4] = '{3, 0, 5, 0, 8'h5A, 8'h4A, 0};   // Z -> J
        vecs[5] = '{20, 1, 4, 0, 8'h7A, 8'h6E, 0};  // z -> n
        vecs[6] = '{26, 0, 1, 0, 8'h43, 8'h41, 0};  // K1=26 is identity: C -> A
        vecs[7] = '{26, 0, 0, 0, 8'h51, 8'h51, 0};  // all-identity keys
        vecs[8] = '{3, 0, 5, 0, 8'h40, 8'h40, 1};   // '@' just below 'A'
        vecs[9] = '{3, 0, 5, 0, 8'h7B, 8'h7B, 1};   // '{' just above 'z'

        rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        out_ready = 1'b1; k1_num = '0; k1_dir = 1'b0; k3_num = '0; k3_dir = 1'b0;
        @(negedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_key_ready", key_ready, 1);
        check("reset_key_err", key_err, 0);
        check("reset_out_char", out_char, 8'h00);
        check("reset_stat_chars", stat_chars, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: each char through an empty pipe, 3-cycle latency.
        for (int i = 0; i < 10; i++) begin
            load_keys(vecs[i].k1n, vecs[i].k1d, vecs[i].k3n, vecs[i].k3d);
            in_valid = 1'b1; in_char = vecs[i].ch;
            #1;
            check("vec_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin tick(); lat++; end
            $display("vec %0d: in=0x%02h out=0x%02h err=%0b latency=%0d", i, vecs[i].ch, out_char, out_char_err, lat);
            check("vec_latency", lat, 3);
            check("vec_char", out_char, vecs[i].exp_ch);
            check("vec_err", out_char_err, vecs[i].exp_err);
            tick();
        end

        // Invalid keys park the FSM in NOKEY with key_err set.
        load_keys(7, 0, 7, 0);
        in_valid = 1'b1; in_char = 8'h41;
        #1;
        check("bad_equal_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        load_keys(27, 0, 1, 0);
        #1;
        check("bad_range_in_ready", in_ready, 0);
        load_keys(3, 0, 5, 0);
        #1;
        check("good_keys_in_ready", in_ready, 1);

        // Backpressure: ABC back-to-back into a stalled output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_char = 8'(8'h41 + i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_char", out_char, 8'h4B);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin tick(); n++; end
        check("bp_drained", exp_q.size(), 0);

        // Key swap with two chars in flight.
        in_valid = 1'b1; in_char = 8'h55;
        tick();
        in_char = 8'h56;
        k1_num = 5'd20; k1_dir = 1'b1; k3_num = 5'd4; k3_dir = 1'b0;
        key_load = 1'b1;
        tick();
        key_load = 1'b0; in_valid = 1'b0;
        check("swap_key_accepted", key_acc, 1);
        check("swap_key_ready", key_ready, 0);
        #1;
        check("swap_in_ready", in_ready, 0);
        n = 0;
        while (!key_ready && n < 20) begin tick(); n++; end
        check("swap_drained", exp_q.size(), 0);
        check("swap_key_ready_back", key_ready, 1);
        in_valid = 1'b1; in_char = 8'h62;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin tick(); n++; end
        check("swap_new_key_done", exp_q.size(), 0);

        // Reset with chars in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_char = 8'h78;
        tick();
        in_char = 8'h79;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_key_ready", key_ready, 1);
        check("rst_key_err", key_err, 0);
        #1;
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        exp_q.delete();
        n_out = 0; n_err = 0;
        out_ready = 1'b1;

        // Randomized stream with occasional key swaps.
        m_k1n = $urandom_range(0, 26);
        do m_k3n = $urandom_range(0, 26); while (m_k3n == m_k1n);
        load_keys(m_k1n, 1'($urandom_range(0, 1)), m_k3n, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 400; i++) begin
            if (!key_load && $urandom_range(0, 99) < 2) begin
                int a, b;
                a = $urandom_range(0, 26);
                do b = $urandom_range(0, 26); while (b == a);
                k1_num = 5'(a); k3_num = 5'(b);
                k1_dir = 1'($urandom_range(0, 1)); k3_dir = 1'($urandom_range(0, 1));
                key_load = 1'b1;
            end
            in_valid  = ($urandom_range(0, 99) < 70);
            in_char   = rand_char();
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
            if (key_acc) key_load = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || !key_ready || key_load) && n < 60) begin
            tick();
            if (key_acc) key_load = 1'b0;
            n++;
        end
        check("random_drained", exp_q.size(), 0);

`ifdef CAESAR_DECIPHER_STATS_EN
        check("stat_chars", stat_chars, n_out);
        check("stat_errs", stat_errs, n_err);
`else
        check("stat_chars_tied", stat_chars, 0);
        check("stat_errs_tied", stat_errs, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
